// File: rtl/alu_result_stage.sv
// Result stage behind the 8-bit ALU: merges flags into the status register, keeps the
// accumulator and a saturating beat counter, and buffers results in a 2-entry skid FIFO.
module alu_result_stage #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_op,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_cout,
  input  logic                 in_ovf,
  input  logic                 in_neg,
  input  logic                 in_zero,
  input  logic                 in_wb,
  input  logic                 sticky_clr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [3:0]           out_flags,
  output logic [3:0]           status_q,
  output logic                 sticky_ovf,
  output logic [WIDTH-1:0]     acc_q,
  output logic [CNT_WIDTH-1:0] op_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] data_mem [2];
  logic [3:0]       flag_mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             accept;
  logic             pop;
  logic             arith;
  logic [3:0]       flags_new;

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_data  = data_mem[rd_ptr];
  assign out_flags = flag_mem[rd_ptr];

  // Logic ops report C/V as 0; keep the previous arithmetic C/V instead.
  assign arith     = (in_op < 3'd3);
  assign flags_new = {in_neg, in_zero,
                      arith ? in_cout : status_q[1],
                      arith ? in_ovf  : status_q[0]};

  always_comb begin
    state_next = state;
    unique case (state)
      EMPTY:   if (accept) state_next = HALF;
      HALF: begin
        if (accept && !pop)      state_next = FULL;
        else if (pop && !accept) state_next = EMPTY;
      end
      FULL:    if (pop) state_next = HALF;
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        data_mem[i] <= '0;
        flag_mem[i] <= '0;
      end
    end else begin
      state <= state_next;
      if (accept) begin
        data_mem[wr_ptr] <= in_data;
        flag_mem[wr_ptr] <= flags_new;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q   <= '0;
      sticky_ovf <= 1'b0;
      acc_q      <= '0;
      op_count   <= '0;
    end else begin
      if (accept) status_q <= flags_new;
      // A new overflow takes priority over a simultaneous clear.
      if (accept && arith && in_ovf) sticky_ovf <= 1'b1;
      else if (sticky_clr)           sticky_ovf <= 1'b0;
      if (accept && in_wb) acc_q <= in_data;
      if (accept && (op_count != '1)) op_count <= op_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: a queue-based reference model checked every cycle,
// plus literal expectations for the scenarios of interest.
module tb_alu_result_stage;

  localparam int W  = 8;
  localparam int CW = 5;
  localparam logic [CW-1:0] CMAX = '1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [2:0]    in_op;
  logic [W-1:0]  in_data;
  logic          in_cout, in_ovf, in_neg, in_zero, in_wb, sticky_clr;
  logic          out_valid, out_ready;
  logic [W-1:0]  out_data;
  logic [3:0]    out_flags, status_q;
  logic          sticky_ovf;
  logic [W-1:0]  acc_q;
  logic [CW-1:0] op_count;

  int errors = 0;
  int checks = 0;
  bit checking = 0;

  alu_result_stage #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_data(in_data), .in_cout(in_cout), .in_ovf(in_ovf), .in_neg(in_neg),
    .in_zero(in_zero), .in_wb(in_wb), .sticky_clr(sticky_clr), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_flags(out_flags),
    .status_q(status_q), .sticky_ovf(sticky_ovf), .acc_q(acc_q), .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of {data, flags} entries plus architectural registers.
  logic [W+3:0]  mq[$];
  logic [3:0]    m_status;
  logic          m_sticky;
  logic [W-1:0]  m_acc;
  logic [CW-1:0] m_cnt;

  always @(posedge clk) begin
    logic acc_ok, do_pop, is_arith;
    logic [3:0] f;
    if (rst) begin
      mq.delete();
      m_status = 4'd0; m_sticky = 1'b0; m_acc = '0; m_cnt = '0;
    end else begin
      acc_ok   = in_valid && (mq.size() < 2);
      do_pop   = (mq.size() > 0) && out_ready;
      is_arith = (in_op == 3'd0) || (in_op == 3'd1) || (in_op == 3'd2);
      if (do_pop) mq.delete(0);
      if (acc_ok) begin
        f = {in_neg, in_zero, is_arith ? in_cout : m_status[1], is_arith ? in_ovf : m_status[0]};
        mq.push_back({in_data, f});
        m_status = f;
        if (in_wb) m_acc = in_data;
        if (m_cnt != CMAX) m_cnt = m_cnt + 1'b1;
      end
      if (acc_ok && is_arith && in_ovf) m_sticky = 1'b1;
      else if (sticky_clr)              m_sticky = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      check("m_out_valid", out_valid, mq.size() != 0);
      check("m_in_ready", in_ready, mq.size() != 2);
      if (mq.size() != 0) begin
        check("m_out_data", out_data, mq[0][W+3:4]);
        check("m_out_flags", out_flags, mq[0][3:0]);
      end
      check("m_status", status_q, m_status);
      check("m_sticky", sticky_ovf, m_sticky);
      check("m_acc", acc_q, m_acc);
      check("m_count", op_count, m_cnt);
    end
  end

  task automatic put(input logic v, input logic [2:0] op, input logic [W-1:0] d,
                     input logic [3:0] nzcv, input logic wb);
    in_valid = v; in_op = op; in_data = d; in_wb = wb;
    {in_neg, in_zero, in_cout, in_ovf} = nzcv;
  endtask

  task automatic idle();
    put(1'b0, 3'd0, '0, 4'd0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; sticky_clr = 1'b0; out_ready = 1'b0;
    idle();
    @(negedge clk); @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_data", out_data, 0);
    check("rst_out_flags", out_flags, 0);
    check("rst_status", status_q, 0);
    check("rst_sticky", sticky_ovf, 0);
    check("rst_acc", acc_q, 0);
    check("rst_count", op_count, 0);
    checking = 1;
    rst = 1'b0;

    // 1: single accept, one-cycle latency
    put(1'b1, 3'd0, 8'h00, 4'b0110, 1'b0);
    @(negedge clk);
    idle();
    check("t1_out_valid", out_valid, 1);
    check("t1_out_data", out_data, 8'h00);
    check("t1_out_flags", out_flags, 4'b0110);
    check("t1_status", status_q, 4'b0110);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // 2: overflow then logic op holding C/V
    put(1'b1, 3'd0, 8'h80, 4'b1001, 1'b0);
    @(negedge clk);
    put(1'b1, 3'd4, 8'h0F, 4'b0000, 1'b0);
    @(negedge clk);
    idle();
    check("t2_status", status_q, 4'b0001);
    check("t2_sticky", sticky_ovf, 1);
    check("t2_head_flags", out_flags, 4'b1001);
    check("t2_full", in_ready, 0);
    out_ready = 1'b1;
    @(negedge clk);
    check("t2_second_flags", out_flags, 4'b0001);
    check("t2_second_data", out_data, 8'h0F);
    @(negedge clk);
    out_ready = 1'b0;

    // 3: back-pressure with three offered beats
    put(1'b1, 3'd1, 8'hA1, 4'b1000, 1'b1);
    @(negedge clk);
    put(1'b1, 3'd5, 8'hA2, 4'b1000, 1'b0);
    @(negedge clk);
    check("t3_stall_ready", in_ready, 0);
    put(1'b1, 3'd2, 8'hA3, 4'b1010, 1'b1);
    @(negedge clk);
    check("t3_stall_count", op_count, 5);
    check("t3_stall_acc", acc_q, 8'hA1);
    out_ready = 1'b1;
    @(negedge clk);
    check("t3_head_a2", out_data, 8'hA2);
    @(negedge clk);
    idle();
    check("t3_head_a3", out_data, 8'hA3);
    check("t3_count", op_count, 6);
    @(negedge clk);
    out_ready = 1'b0;

    // 4: streaming in HALF
    put(1'b1, 3'd0, 8'hB0, 4'b1000, 1'b0);
    @(negedge clk);
    check("t4_start_count", op_count, 7);
    out_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      put(1'b1, 3'd3, 8'hB0 + 8'(i), 4'b1000, 1'b0);
      @(negedge clk);
    end
    idle();
    check("t4_count", op_count, 17);
    check("t4_last_head", out_data, 8'hBA);
    @(negedge clk);

    // 5: sticky set/clear priority; non-arith ovf ignored
    sticky_clr = 1'b1;
    @(negedge clk);
    check("t5_cleared", sticky_ovf, 0);
    put(1'b1, 3'd1, 8'h7F, 4'b0011, 1'b0);
    @(negedge clk);
    idle();
    check("t5_set_wins", sticky_ovf, 1);
    @(negedge clk);
    check("t5_clear_alone", sticky_ovf, 0);
    sticky_clr = 1'b0;
    put(1'b1, 3'd3, 8'h00, 4'b0001, 1'b0);
    @(negedge clk);
    idle();
    check("t5_logic_no_sticky", sticky_ovf, 0);
    check("t5_logic_cv_held", status_q, 4'b0011);
    @(negedge clk);
    out_ready = 1'b0;

    // 6: reset while FULL
    put(1'b1, 3'd4, 8'h11, 4'b0000, 1'b0);
    @(negedge clk);
    put(1'b1, 3'd4, 8'h5A, 4'b0000, 1'b1);
    @(negedge clk);
    idle();
    check("t6_acc", acc_q, 8'h5A);
    check("t6_full", in_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_out_valid", out_valid, 0);
    check("t6_in_ready", in_ready, 1);
    check("t6_acc_rst", acc_q, 0);
    check("t6_count_rst", op_count, 0);

    // counter saturation
    out_ready = 1'b1;
    for (int i = 0; i < 35; i++) begin
      put(1'b1, 3'd6, 8'(i), 4'b0000, 1'b0);
      @(negedge clk);
    end
    idle();
    check("sat_count", op_count, 31);
    @(negedge clk);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
